// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer controller: loads FOLD weight/threshold words, then sweeps folds per activation.
// Latency: activation accepted at T gives res_valid first at T+1+FOLD+PIPE_LAT; load beats are written the same cycle.
// Backpressure: ld_ready only in LOAD, act_ready only when idle and loaded, res_valid held until res_ready.
//
// Optional feature macro: FC_LAYER_CTRL_PERF_CNT_EN adds saturating perf_infer_cnt / perf_stall_cnt outputs.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   load_start                      pulse in IDLE that begins a full weight/threshold load
//   ld_valid / ld_ready             one weight+threshold word per handshake beat
//   stream_w_en/_addr,
//   stream_th_en/_addr              datapath write strobes and addresses (load counter)
//   act_valid / act_ready           activation vector handshake
//   stream_act_en                   activation capture strobe, same cycle as the accept
//   fold_addr                       datapath fold read address
//   res_valid / res_ready           completed output vector handshake
//   busy, loaded, err_not_loaded    status: not idle, weights present, rejected activation
module fc_layer_ctrl #(
    parameter int FOLD     = 64,
    parameter int FOLD_LOG = (FOLD == 1) ? 1 : $clog2(FOLD),
    parameter int PIPE_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                ld_valid,
    output logic                ld_ready,
    output logic                stream_w_en,
    output logic                stream_th_en,
    output logic [FOLD_LOG-1:0] stream_w_addr,
    output logic [FOLD_LOG-1:0] stream_th_addr,
    input  logic                act_valid,
    output logic                act_ready,
    output logic                stream_act_en,
    output logic [FOLD_LOG-1:0] fold_addr,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                loaded,
    output logic                err_not_loaded
`ifdef FC_LAYER_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_infer_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    // Wait counter only needs to reach PIPE_LAT-1; keep at least one bit.
    localparam int WAIT_W = (PIPE_LAT <= 1) ? 1 : $clog2(PIPE_LAT);

    localparam logic [FOLD_LOG-1:0] LAST_FOLD = FOLD_LOG'(FOLD - 1);
    localparam logic [WAIT_W-1:0]   LAST_WAIT = (PIPE_LAT == 0) ? '0 : WAIT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SWEEP = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [FOLD_LOG-1:0] ld_cnt;
    logic [FOLD_LOG-1:0] fold_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                loaded_q;

    // Handshake qualifiers shared by next-state, output and counter logic.
    logic ld_beat;
    logic ld_last;
    logic act_accept;
    logic fold_last;
    logic wait_last;
    logic res_done;

    assign ld_beat    = (state == S_LOAD) && ld_valid;
    assign ld_last    = ld_beat && (ld_cnt == LAST_FOLD);
    // load_start wins over act_valid, so an activation is never accepted in the cycle a load begins.
    assign act_accept = (state == S_IDLE) && loaded_q && !load_start && act_valid;
    assign fold_last  = (state == S_SWEEP) && (fold_cnt == LAST_FOLD);
    assign wait_last  = (state == S_WAIT) && (wait_cnt == LAST_WAIT);
    assign res_done   = (state == S_HOLD) && res_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                end else if (act_accept) begin
                    state_nxt = S_SWEEP;
                end
            end
            S_LOAD: begin
                if (ld_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SWEEP: begin
                // With no pipeline latency the result is ready right after the last fold.
                if (fold_last) begin
                    state_nxt = (PIPE_LAT == 0) ? S_HOLD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_last) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        ld_ready       = 1'b0;
        stream_w_en    = 1'b0;
        stream_th_en   = 1'b0;
        act_ready      = 1'b0;
        stream_act_en  = 1'b0;
        fold_addr      = '0;
        res_valid      = 1'b0;
        err_not_loaded = 1'b0;
        case (state)
            S_IDLE: begin
                act_ready      = loaded_q && !load_start;
                stream_act_en  = act_accept;
                err_not_loaded = act_valid && !loaded_q && !load_start;
            end
            S_LOAD: begin
                ld_ready     = 1'b1;
                stream_w_en  = ld_valid;
                stream_th_en = ld_valid;
            end
            S_SWEEP: begin
                fold_addr = fold_cnt;
            end
            S_WAIT: begin
                // Keep the last fold address stable while the datapath drains.
                fold_addr = LAST_FOLD;
            end
            S_HOLD: begin
                fold_addr = LAST_FOLD;
                res_valid = 1'b1;
            end
            default: begin
                fold_addr = '0;
            end
        endcase
    end

    // Weights and thresholds are written to the same slot on every beat.
    assign stream_w_addr  = ld_cnt;
    assign stream_th_addr = ld_cnt;
    assign busy           = (state != S_IDLE);
    assign loaded         = loaded_q;

    // ------------------------------------------------------------------
    // Counters and load status
    // ------------------------------------------------------------------
    // Every counter clears on its final value instead of wrapping, so none ever exceeds its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt <= '0;
        end else if ((state == S_IDLE) && load_start) begin
            ld_cnt <= '0;
        end else if (ld_beat) begin
            ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fold_cnt <= '0;
        end else if (state == S_SWEEP) begin
            fold_cnt <= fold_last ? '0 : fold_cnt + 1'b1;
        end else begin
            fold_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A reset or a new load invalidates the stored weights until the final beat lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_q <= 1'b0;
        end else if ((state == S_IDLE) && load_start) begin
            loaded_q <= 1'b0;
        end else if (ld_last) begin
            loaded_q <= 1'b1;
        end
    end

`ifdef FC_LAYER_CTRL_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_infer_cnt <= '0;
        end else if (res_done && (perf_infer_cnt != '1)) begin
            perf_infer_cnt <= perf_infer_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
        end else if ((state == S_HOLD) && !res_ready && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
module tb_fc_layer_ctrl;

    localparam int FOLD     = 4;
    localparam int FOLD_LOG = 2;
    localparam int PIPE_LAT = 2;

    logic                clk;
    logic                reset;
    logic                load_start;
    logic                ld_valid;
    logic                ld_ready;
    logic                stream_w_en;
    logic                stream_th_en;
    logic [FOLD_LOG-1:0] stream_w_addr;
    logic [FOLD_LOG-1:0] stream_th_addr;
    logic                act_valid;
    logic                act_ready;
    logic                stream_act_en;
    logic [FOLD_LOG-1:0] fold_addr;
    logic                res_valid;
    logic                res_ready;
    logic                busy;
    logic                loaded;
    logic                err_not_loaded;
`ifdef FC_LAYER_CTRL_PERF_CNT_EN
    logic [31:0]         perf_infer_cnt;
    logic [31:0]         perf_stall_cnt;
`endif

    int vectors;
    int miscompares;

    fc_layer_ctrl #(
        .FOLD     (FOLD),
        .FOLD_LOG (FOLD_LOG),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .stream_w_en    (stream_w_en),
        .stream_th_en   (stream_th_en),
        .stream_w_addr  (stream_w_addr),
        .stream_th_addr (stream_th_addr),
        .act_valid      (act_valid),
        .act_ready      (act_ready),
        .stream_act_en  (stream_act_en),
        .fold_addr      (fold_addr),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .busy           (busy),
        .loaded         (loaded),
        .err_not_loaded (err_not_loaded)
`ifdef FC_LAYER_CTRL_PERF_CNT_EN
        ,
        .perf_infer_cnt (perf_infer_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs 2 units after the edge before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        load_start  = 1'b0;
        ld_valid    = 1'b0;
        act_valid   = 1'b0;
        res_ready   = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_loaded",    32'(loaded),        32'd0);
        chk("rst_fold_addr", 32'(fold_addr),     32'd0);
        chk("rst_res_valid", 32'(res_valid),     32'd0);
        chk("rst_ld_ready",  32'(ld_ready),      32'd0);
        chk("rst_w_en",      32'(stream_w_en),   32'd0);
        chk("rst_err",       32'(err_not_loaded), 32'd0);
`ifdef FC_LAYER_CTRL_PERF_CNT_EN
        chk("rst_perf_infer", perf_infer_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif

        // ---- activation before any load is rejected ----
        tick();
        act_valid = 1'b1;
        settle();
        chk("nl_err",       32'(err_not_loaded), 32'd1);
        chk("nl_act_ready", 32'(act_ready),      32'd0);
        chk("nl_act_en",    32'(stream_act_en),  32'd0);
        tick();
        act_valid = 1'b0;
        settle();
        chk("nl_err_once", 32'(err_not_loaded), 32'd0);
        chk("nl_busy",     32'(busy),           32'd0);

        // ---- load_start and act_valid together: load wins ----
        tick();
        load_start = 1'b1;
        act_valid  = 1'b1;
        settle();
        chk("pri_act_ready", 32'(act_ready),      32'd0);
        chk("pri_act_en",    32'(stream_act_en),  32'd0);
        chk("pri_err",       32'(err_not_loaded), 32'd0);
        tick();
        load_start = 1'b0;
        act_valid  = 1'b0;
        settle();
        chk("pri_busy",     32'(busy),     32'd1);
        chk("pri_ld_ready", 32'(ld_ready), 32'd1);

        // ---- reset after two load beats abandons the load ----
        ld_valid = 1'b1;
        settle();
        chk("ab_w_en0",  32'(stream_w_en),   32'd1);
        chk("ab_addr0",  32'(stream_w_addr), 32'd0);
        tick();
        settle();
        chk("ab_addr1",  32'(stream_w_addr), 32'd1);
        tick();
        ld_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("ab_loaded", 32'(loaded), 32'd0);
        chk("ab_busy",   32'(busy),   32'd0);
        act_valid = 1'b1;
        settle();
        chk("ab_err",    32'(err_not_loaded), 32'd1);
        tick();
        act_valid = 1'b0;

        // ---- full load of 4 beats ----
        load_start = 1'b1;
        settle();
        chk("ld_idle_busy", 32'(busy), 32'd0);
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b1;
        for (int i = 0; i < FOLD; i++) begin
            settle();
            chk("ld_w_en",    32'(stream_w_en),    32'd1);
            chk("ld_th_en",   32'(stream_th_en),   32'd1);
            chk("ld_w_addr",  32'(stream_w_addr),  32'(i));
            chk("ld_th_addr", 32'(stream_th_addr), 32'(i));
            chk("ld_loaded",  32'(loaded),         32'd0);
            chk("ld_fold0",   32'(fold_addr),      32'd0);
            tick();
        end
        ld_valid = 1'b0;
        settle();
        chk("ld_done_loaded", 32'(loaded),      32'd1);
        chk("ld_done_busy",   32'(busy),        32'd0);
        chk("ld_done_w_en",   32'(stream_w_en), 32'd0);
        chk("ld_act_ready",   32'(act_ready),   32'd1);

        // ---- inference with res_ready=1: T accept, folds T+1..T+4, result T+7 ----
        act_valid = 1'b1;
        res_ready = 1'b1;
        settle();
        chk("inf_act_en",    32'(stream_act_en), 32'd1);
        chk("inf_act_ready", 32'(act_ready),     32'd1);
        tick();
        act_valid = 1'b0;
        for (int k = 0; k < FOLD; k++) begin
            settle();
            chk("inf_fold_addr", 32'(fold_addr),     32'(k));
            chk("inf_busy",      32'(busy),          32'd1);
            chk("inf_res_valid", 32'(res_valid),     32'd0);
            chk("inf_act_ready", 32'(act_ready),     32'd0);
            tick();
        end
        for (int w = 0; w < PIPE_LAT; w++) begin
            settle();
            chk("inf_wait_addr",  32'(fold_addr), 32'd3);
            chk("inf_wait_valid", 32'(res_valid), 32'd0);
            tick();
        end
        settle();
        chk("inf_res_valid_hi", 32'(res_valid), 32'd1);
        chk("inf_hold_addr",    32'(fold_addr), 32'd3);
        tick();
        settle();
        chk("inf_idle_busy",  32'(busy),      32'd0);
        chk("inf_idle_valid", 32'(res_valid), 32'd0);
        chk("inf_idle_addr",  32'(fold_addr), 32'd0);
        chk("inf_loaded",     32'(loaded),    32'd1);

        // ---- inference with res_ready held low for 5 cycles ----
        res_ready = 1'b0;
        act_valid = 1'b1;
        settle();
        chk("st_act_en", 32'(stream_act_en), 32'd1);
        tick();
        act_valid = 1'b0;
        repeat (FOLD + PIPE_LAT) tick();
        for (int s = 0; s < 5; s++) begin
            settle();
            chk("st_res_valid", 32'(res_valid), 32'd1);
            chk("st_fold_addr", 32'(fold_addr), 32'd3);
            tick();
        end
`ifdef FC_LAYER_CTRL_PERF_CNT_EN
        chk("st_perf_stall", perf_stall_cnt, 32'd5);
`endif
        res_ready = 1'b1;
        settle();
        chk("st_release_valid", 32'(res_valid), 32'd1);
        tick();
        res_ready = 1'b0;
        settle();
        chk("st_idle_busy",  32'(busy),      32'd0);
        chk("st_idle_valid", 32'(res_valid), 32'd0);
`ifdef FC_LAYER_CTRL_PERF_CNT_EN
        chk("st_perf_infer", perf_infer_cnt, 32'd2);
        chk("st_perf_stall_hold", perf_stall_cnt, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 SHALL have parameter FOLD, default 64, giving the number of folds per inference (FOLD >= 1).
REQ-002 SHALL have parameter FOLD_LOG, default (FOLD==1)?1:$clog2(FOLD), giving the fold address width.
REQ-003 SHALL have parameter PIPE_LAT, default 2, giving the cycles from the last fold_addr to a valid datapath output.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port load_start, input, 1, a pulse that begins a weight/threshold load.
REQ-007 SHALL have port ld_valid, input, 1, meaning the host presents one weight+threshold word.
REQ-008 SHALL have port ld_ready, output, 1, meaning the controller accepts a load word.
REQ-009 SHALL have ports stream_w_en and stream_th_en, output, 1 each, as datapath write enables.
REQ-010 SHALL have ports stream_w_addr and stream_th_addr, output, FOLD_LOG each, as datapath write addresses.
REQ-011 SHALL have port act_valid, input, 1, meaning an activation vector is offered.
REQ-012 SHALL have port act_ready, output, 1, meaning the controller accepts an activation.
REQ-013 SHALL have port stream_act_en, output, 1, the activation capture strobe to the datapath.
REQ-014 SHALL have port fold_addr, output, FOLD_LOG, the datapath fold read address.
REQ-015 SHALL have port res_valid, output, 1, meaning the datapath output vector is complete.
REQ-016 SHALL have port res_ready, input, 1, meaning the downstream consumes the result.
REQ-017 SHALL have ports busy, loaded and err_not_loaded, output, 1 each: busy = not IDLE; loaded = load complete; err_not_loaded = one-cycle pulse on a rejected activation.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SWEEP, WAIT and HOLD.
REQ-019 SHALL, in IDLE, on load_start go to LOAD, clear loaded and clear the load counter; load_start SHALL take priority over act_valid in the same cycle.
REQ-020 SHALL, in LOAD, hold ld_ready=1; on each ld_valid&ld_ready beat SHALL assert stream_w_en=stream_th_en=1 combinationally with both addresses equal to the load counter, then increment the counter.
REQ-021 SHALL, on the beat at address FOLD-1, set loaded=1 and return to IDLE; load_start SHALL be ignored while in LOAD.
REQ-022 SHALL drive act_ready = (IDLE & loaded & !load_start); on act_valid&act_ready SHALL assert stream_act_en the same cycle and enter SWEEP.
REQ-023 SHALL, on act_valid in IDLE with loaded=0 and no load_start, pulse err_not_loaded for one cycle and not accept the activation.
REQ-024 SHALL, in SWEEP, present fold_addr=k in cycle T+1+k (T = accept cycle) for k = 0..FOLD-1, then enter WAIT; with FOLD==1, SWEEP SHALL last one cycle.
REQ-025 SHALL, in WAIT, hold fold_addr=FOLD-1 for PIPE_LAT cycles, then enter HOLD.
REQ-026 SHALL, in HOLD, assert res_valid (first at T+1+FOLD+PIPE_LAT) until res_ready, then return to IDLE in the next cycle.
REQ-027 SHALL hold fold_addr=0 in IDLE and LOAD, and SHALL keep stream_w_en/stream_th_en at 0 outside LOAD.
REQ-028 SHALL have all counters wrap-free: the load counter and fold counter SHALL never exceed FOLD-1.

Reset
REQ-029 SHALL, on reset, enter IDLE and clear loaded, counters, res_valid, err_not_loaded, busy, fold_addr and all enables to 0.
REQ-030 SHALL, on reset mid-LOAD or mid-inference, abandon the operation, leaving loaded=0 so that a full reload is required.

Configuration
REQ-031 SHALL, with macro FC_LAYER_CTRL_PERF_CNT_EN defined, add output perf_infer_cnt (32 bits, increments on each res_valid&res_ready) and perf_stall_cnt (32 bits, increments each HOLD cycle with res_ready=0); both SHALL saturate at all-ones and clear on reset.
REQ-032 SHALL, without FC_LAYER_CTRL_PERF_CNT_EN defined, omit these ports and the counter logic entirely.

Verification (FOLD=4, PIPE_LAT=2)
REQ-033 SHALL cover: load_start then 4 beats with ld_valid=1 -> stream_w_en on addresses 0,1,2,3; loaded=1 after beat 3; state IDLE.
REQ-034 SHALL cover: act_valid accepted at cycle 10, res_ready=1 -> fold_addr 0..3 in cycles 11..14; res_valid at cycle 17; IDLE at cycle 18.
REQ-035 SHALL cover: act_valid before any load -> err_not_loaded pulses once; act_ready=0; stream_act_en=0.
REQ-036 SHALL cover: res_ready held 0 for 5 cycles -> res_valid stays 1 and fold_addr stays 3; with the macro defined, perf_stall_cnt=5.
REQ-037 SHALL cover: reset asserted after 2 load beats -> loaded=0 and IDLE; a subsequent act_valid raises err_not_loaded.
REQ-038 SHALL cover: load_start and act_valid in the same IDLE cycle -> LOAD entered; act_ready=0; no stream_act_en.
